// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: raster timing for the 800x480 LCD panel.
// Produces scan coordinates, active-low sync strobes, data-enable, a frame
// start pulse and a valid flag for the colour lookup block. The counters step
// on pix_ce strobes in the clk domain.
// Build option: define LCD_FRAME_COUNTER_EN to add the frame_count output.
module lcd_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_SYNC   = 48,
  parameter int unsigned H_BACK   = 88,
  parameter int unsigned H_FRONT  = 40,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 32,
  parameter int unsigned V_FRONT  = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pix_ce,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic        frame_start,
  output logic        valid
`ifdef LCD_FRAME_COUNTER_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [10:0] X_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] X_DE_BEG   = 11'(H_BACK);
  localparam logic [10:0] X_DE_END   = 11'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0]  Y_DE_BEG   = 10'(V_BACK);
  localparam logic [9:0]  Y_DE_END   = 10'(V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNCING = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t      state_q;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hsync_n_q, vsync_n_q, de_q, frame_start_q, valid_q;
  logic        hsync_n_d, vsync_n_d, de_d;
  logic        frame_wrap;

  // Next scan position and its decodes; leaving IDLE always lands on (0,0).
  always_comb begin
    x_d        = 11'd0;
    y_d        = 10'd0;
    frame_wrap = 1'b0;
    if (state_q != IDLE) begin
      frame_wrap = (x_q == X_LAST) && (y_q == Y_LAST);
      if (x_q == X_LAST) begin
        x_d = 11'd0;
        y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 11'd1;
        y_d = y_q;
      end
    end
    hsync_n_d = !(x_d < X_SYNC_END);
    vsync_n_d = !(y_d < Y_SYNC_END);
    de_d      = (x_d >= X_DE_BEG) && (x_d < X_DE_END) &&
                (y_d >= Y_DE_BEG) && (y_d < Y_DE_END);
  end

  // Sequencer and registered timing outputs; enable low overrides pix_ce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      x_q           <= 11'd0;
      y_q           <= 10'd0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      valid_q       <= 1'b0;
    end else if (!enable) begin
      state_q       <= IDLE;
      x_q           <= 11'd0;
      y_q           <= 10'd0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (pix_ce) begin
        x_q       <= x_d;
        y_q       <= y_d;
        hsync_n_q <= hsync_n_d;
        vsync_n_q <= vsync_n_d;
        de_q      <= de_d;
        case (state_q)
          IDLE: begin
            state_q       <= SYNCING;
            frame_start_q <= 1'b1;
          end
          SYNCING: begin
            if (frame_wrap) begin
              state_q       <= RUN;
              valid_q       <= 1'b1;
              frame_start_q <= 1'b1;
            end
          end
          RUN: begin
            if (frame_wrap) frame_start_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign de          = de_q;
  assign frame_start = frame_start_q;
  assign valid       = valid_q;

`ifdef LCD_FRAME_COUNTER_EN
  logic [15:0] fc_q;

  // Counts frames started while already in RUN; the frame_start that raises
  // valid is not counted. Entering IDLE clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_q <= 16'd0;
    end else if (!enable) begin
      fc_q <= 16'd0;
    end else if (pix_ce && (state_q == RUN) && frame_wrap) begin
      fc_q <= fc_q + 16'd1;
    end
  end

  assign frame_count = fc_q;
`else
  // No frame counter in this build.
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
module tb_lcd_timing_gen;

  localparam int HA = 8, HS = 2, HB = 4, HF = 3;
  localparam int VA = 5, VS = 1, VB = 3, VF = 2;
  localparam int HT = HB + HA + HF;   // 15
  localparam int VT = VB + VA + VF;   // 10
  localparam int FR = HT * VT;        // 150 strobes per frame

  localparam logic [25:0] IDLE_OUT = {11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst, enable, pix_ce;

  logic [10:0] x;
  logic [9:0]  y;
  logic        hsync_n, vsync_n, de, frame_start, valid;

  logic [10:0] dx;
  logic [9:0]  dy;
  logic        dhs, dvs, dde, dfs, dvalid;

`ifdef LCD_FRAME_COUNTER_EN
  logic [15:0] frame_count, dfc;
`endif

  logic [25:0] obs;
  assign obs = {x, y, hsync_n, vsync_n, de, frame_start, valid};

  int total = 0;
  int bad   = 0;
  int m_idx;
  bit m_valid;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_FRONT(HF),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_ce(pix_ce),
    .x(x), .y(y), .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de),
    .frame_start(frame_start), .valid(valid)
`ifdef LCD_FRAME_COUNTER_EN
    , .frame_count(frame_count)
`endif
  );

  lcd_timing_gen dut_def (
    .clk(clk), .rst(rst), .enable(enable), .pix_ce(pix_ce),
    .x(dx), .y(dy), .hsync_n(dhs), .vsync_n(dvs), .de(dde),
    .frame_start(dfs), .valid(dvalid)
`ifdef LCD_FRAME_COUNTER_EN
    , .frame_count(dfc)
`endif
  );

  // Reference raster for the reduced-size instance.
  function automatic logic [25:0] exp_out(int idx, bit fs, bit vld);
    int ex, ey;
    if (idx < 0) return IDLE_OUT;
    ex = idx % HT;
    ey = (idx / HT) % VT;
    return {11'(ex), 10'(ey), (ex >= HS), (ey >= VS),
            (ex >= HB && ex < HB + HA && ey >= VB && ey < VB + VA), fs, vld};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_strobe(output bit fs);
    m_idx = m_idx + 1;
    fs = (m_idx % FR == 0);
    if (fs && m_idx > 0) m_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; pix_ce = 1'b0;
    m_idx = -1; m_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix_ce = i[0];
      step();
      total++;
      if (obs !== IDLE_OUT) begin
        bad++;
        $display("FAIL reset_held i=%0d got=%h exp=%h", i, obs, IDLE_OUT);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pix_ce = i[0];
      step();
      total++;
      if (obs !== IDLE_OUT) begin
        bad++;
        $display("FAIL reset_idle_en0 i=%0d got=%h exp=%h", i, obs, IDLE_OUT);
      end
    end
  endtask

  task automatic test_window_continuous();
    bit fs;
    logic [25:0] e;
    enable = 1'b1; pix_ce = 1'b1;
    for (int k = 0; k < 29790; k++) begin
      step();
      run_strobe(fs);
      e = exp_out(m_idx, fs, m_valid);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL window idx=%0d got=%h exp=%h", m_idx, obs, e);
      end
      case (m_idx)
        0: begin
          total++;
          if ({dx, dy, dhs, dvs, dde, dfs, dvalid} !== {11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL def_entry got=%0d,%0d hs=%b vs=%b de=%b fs=%b v=%b exp=0,0 hs=0 vs=0 de=0 fs=1 v=0",
                     dx, dy, dhs, dvs, dde, dfs, dvalid);
          end
        end
        47: begin
          total++;
          if (dhs !== 1'b0 || dx !== 11'd47) begin
            bad++;
            $display("FAIL def_hsync_last x=%0d hs=%b exp x=47 hs=0", dx, dhs);
          end
        end
        48: begin
          total++;
          if (dhs !== 1'b1) begin
            bad++;
            $display("FAIL def_hsync_end x=%0d hs=%b exp hs=1", dx, dhs);
          end
        end
        928: begin
          total++;
          if (dx !== 11'd0 || dy !== 10'd1 || dhs !== 1'b0) begin
            bad++;
            $display("FAIL def_line_wrap got=%0d,%0d hs=%b exp=0,1 hs=0", dx, dy, dhs);
          end
        end
        29783: begin
          total++;
          if (dde !== 1'b0 || dvs !== 1'b1 || dx !== 11'd87 || dy !== 10'd32) begin
            bad++;
            $display("FAIL def_de_before got=%0d,%0d de=%b vs=%b exp=87,32 de=0 vs=1", dx, dy, dde, dvs);
          end
        end
        29784: begin
          total++;
          if (dde !== 1'b1 || dx !== 11'd88 || dy !== 10'd32) begin
            bad++;
            $display("FAIL def_de_first got=%0d,%0d de=%b exp=88,32 de=1", dx, dy, dde);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_pix_ce_div3();
    bit fs;
    logic [25:0] e;
    int last0 = -1;
    for (int c = 0; c < 120; c++) begin
      pix_ce = (c % 3 == 0);
      step();
      fs = 1'b0;
      if (pix_ce) run_strobe(fs);
      e = exp_out(m_idx, fs, m_valid);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL div3 c=%0d got=%h exp=%h", c, obs, e);
      end
      if (pix_ce && x == 11'd0) begin
        if (last0 >= 0) begin
          total++;
          if (c - last0 != 3 * HT) begin
            bad++;
            $display("FAIL div3_line_len got=%0d exp=%0d", c - last0, 3 * HT);
          end
        end
        last0 = c;
      end
    end
    pix_ce = 1'b1;
  endtask

  task automatic test_enable_drop();
    bit fs;
    logic [25:0] e;
    int n = 0;
    pix_ce = 1'b1;
    while ((m_idx % FR) != 4 * HT + 6 && n < 2 * FR) begin
      step();
      run_strobe(fs);
      e = exp_out(m_idx, fs, m_valid);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL drop_approach idx=%0d got=%h exp=%h", m_idx, obs, e);
      end
      n++;
    end
    total++;
    if (x !== 11'd6 || y !== 10'd4 || valid !== 1'b1) begin
      bad++;
      $display("FAIL drop_position got=%0d,%0d v=%b exp=6,4 v=1", x, y, valid);
    end
    enable = 1'b0;
    step();
    m_idx = -1; m_valid = 1'b0;
    total++;
    if (obs !== IDLE_OUT) begin
      bad++;
      $display("FAIL drop_idle got=%h exp=%h", obs, IDLE_OUT);
    end
    enable = 1'b1; pix_ce = 1'b0;
    step();
    total++;
    if (obs !== IDLE_OUT) begin
      bad++;
      $display("FAIL drop_wait_strobe got=%h exp=%h", obs, IDLE_OUT);
    end
    pix_ce = 1'b1;
    for (int k = 0; k < FR + 1; k++) begin
      step();
      run_strobe(fs);
      e = exp_out(m_idx, fs, m_valid);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL drop_restart idx=%0d got=%h exp=%h", m_idx, obs, e);
      end
    end
    total++;
    if (valid !== 1'b1 || frame_start !== 1'b1) begin
      bad++;
      $display("FAIL drop_valid_return v=%b fs=%b exp v=1 fs=1", valid, frame_start);
    end
  endtask

  task automatic test_async_reset();
    bit fs;
    logic [25:0] e;
    int n = 0;
    while ((m_idx % FR) != 6 * HT + 8 && n < 2 * FR) begin
      step();
      run_strobe(fs);
      n++;
    end
    total++;
    if (x !== 11'd8 || y !== 10'd6) begin
      bad++;
      $display("FAIL arst_position got=%0d,%0d exp=8,6", x, y);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== IDLE_OUT) begin
      bad++;
      $display("FAIL arst_immediate got=%h exp=%h", obs, IDLE_OUT);
    end
    @(negedge clk);
    total++;
    if (obs !== IDLE_OUT) begin
      bad++;
      $display("FAIL arst_held got=%h exp=%h", obs, IDLE_OUT);
    end
    rst = 1'b0;
    m_idx = -1; m_valid = 1'b0;
    enable = 1'b1; pix_ce = 1'b1;
    for (int k = 0; k < FR + 1; k++) begin
      step();
      run_strobe(fs);
      e = exp_out(m_idx, fs, m_valid);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL arst_powerup idx=%0d got=%h exp=%h", m_idx, obs, e);
      end
    end
  endtask

`ifdef LCD_FRAME_COUNTER_EN
  task automatic test_frame_counter();
    total++;
    if (frame_count !== 16'd0) begin
      bad++;
      $display("FAIL fc_at_valid got=%0d exp=0", frame_count);
    end
    repeat (3 * FR) step();
    total++;
    if (frame_count !== 16'd3) begin
      bad++;
      $display("FAIL fc_three_frames got=%0d exp=3", frame_count);
    end
    force dut.fc_q = 16'hFFFF;
    #1;
    release dut.fc_q;
    repeat (FR - 1) step();
    total++;
    if (frame_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL fc_preload got=%h exp=ffff", frame_count);
    end
    step();
    total++;
    if (frame_count !== 16'd0) begin
      bad++;
      $display("FAIL fc_wrap got=%h exp=0000", frame_count);
    end
    repeat (FR) step();
    total++;
    if (frame_count !== 16'd1) begin
      bad++;
      $display("FAIL fc_after_wrap got=%0d exp=1", frame_count);
    end
    enable = 1'b0;
    step();
    total++;
    if (frame_count !== 16'd0) begin
      bad++;
      $display("FAIL fc_clear got=%0d exp=0", frame_count);
    end
    enable = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; pix_ce = 1'b0;
    @(negedge clk);
    test_reset();
    test_window_continuous();
    test_pix_ce_div3();
    test_enable_drop();
    test_async_reset();
`ifdef LCD_FRAME_COUNTER_EN
    test_frame_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Generates raster timing for the 800x480 LCD panel: x/y scan coordinates, sync strobes, data-enable and a frame-valid flag.
- Its outputs drive the pixel colour lookup block, which takes x, y and valid and returns r/g/b. It also drives the panel sync/DE pins.
- Counters advance once per pixel-clock enable strobe from the system clock domain.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_SYNC, 48, hsync pulse width in pixels, starting at x=0
- H_BACK, 88, sync+back-porch width; first active x = H_BACK
- H_FRONT, 40, front porch after the active region
- V_ACTIVE, 480, visible lines per frame
- V_SYNC, 3, vsync pulse width in lines, starting at y=0
- V_BACK, 32, sync+back-porch lines; first active y = V_BACK
- V_FRONT, 13, front porch lines

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous active-high reset
- enable, input, 1, run timing; low forces idle
- pix_ce, input, 1, pixel strobe; counters step only when high
- x, output, 11, horizontal position 0..H_TOTAL-1
- y, output, 10, vertical position 0..V_TOTAL-1
- hsync_n, output, 1, active-low hsync
- vsync_n, output, 1, active-low vsync
- de, output, 1, high inside the active window
- frame_start, output, 1, one-clk pulse when position (0,0) is entered
- valid, output, 1, timing stable; feeds the colour block valid input

Behaviour:
- Derived totals:
  - H_TOTAL = H_BACK + H_ACTIVE + H_FRONT (928)
  - V_TOTAL = V_BACK + V_ACTIVE + V_FRONT (525)
- Reset: rst high asynchronously sets:
  - x=0, y=0
  - hsync_n=1, vsync_n=1, de=0, frame_start=0, valid=0
  - state=IDLE
- All outputs are registered. x, y, hsync_n, vsync_n and de always describe the same counter position in the same cycle.
- Counter step on a clk edge with pix_ce=1 and state!=IDLE:
  - x wraps H_TOTAL-1 -> 0.
  - y increments only when x wraps.
  - y wraps V_TOTAL-1 -> 0.
- When pix_ce=0, all counters and levels hold. frame_start is 0.
- Decodes from the new (x, y):
  - hsync_n = !(x < H_SYNC)
  - vsync_n = !(y < V_SYNC)
  - de = (H_BACK <= x < H_BACK+H_ACTIVE) && (V_BACK <= y < V_BACK+V_ACTIVE)
- frame_start: high exactly one clk, in the cycle where the counter transitions into (0,0) from (H_TOTAL-1, V_TOTAL-1). It is also high on the IDLE->SYNCING entry.
- State machine:
  - IDLE: counters held at 0, all levels inactive, valid=0. Leaves to SYNCING on the first clk with enable=1 and pix_ce=1. That strobe enters (0,0) and asserts frame_start; the entry cycle's decodes are hsync_n=0, vsync_n=0, de=0.
  - SYNCING: counters run, valid=0. Goes to RUN when the next frame_start is generated; valid=1 in that same cycle.
  - RUN: counters run, valid=1.
- Any state, enable=0 on a clk edge: next cycle is IDLE with counters=0, levels inactive, valid=0. Takes priority over pix_ce.
- enable low for a single cycle still forces the full IDLE/SYNCING sequence; valid drops for at least one frame.
- Width rules: x is 11 bits, y is 10 bits; both totals fit. Parameters are assumed to satisfy H_SYNC <= H_BACK and V_SYNC <= V_BACK. Comparisons are unsigned.

Optional Feature:
- Macro: LCD_FRAME_COUNTER_EN.
- Defined:
  - Adds output frame_count[15:0], reset to 0.
  - Increments by 1 with each frame_start while state is RUN, wrapping 0xFFFF -> 0.
  - Clears to 0 on entry to IDLE.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- rst high, then release with enable=0 and pix_ce toggling -> x=0, y=0, hsync_n=1, vsync_n=1, de=0, valid=0, frame_start never pulses.
- enable=1, pix_ce=1 every clk -> frame_start at entry and again 928*525=487200 strobes later. valid rises in that second frame_start cycle. hsync_n low for x=0..47, de first high at (88,32), last high at (887,511).
- pix_ce=1 every 3rd clk in RUN -> x advances only on strobe cycles. All outputs hold between strobes. Line length is 928 strobes (2784 clk).
- Drop enable for 1 clk at (400,300) in RUN -> next cycle x=0, y=0, valid=0, de=0. The first strobe after enable returns restarts at (0,0) with frame_start. valid returns after one full frame.
- Assert rst asynchronously mid-line at (500,100) -> outputs reset immediately, not at the next clk edge. After release, behaviour matches the power-up sequence.
- LCD_FRAME_COUNTER_EN defined, run 3 full frames after valid -> frame_count=3 (the frame_start that raises valid does not count). Preload near 0xFFFF via long run or force -> wraps to 0. Toggling enable clears it to 0.
